// File: rtl/spi_word_assembler.sv
// Collects SPI receive bytes into NUM_BYTES-wide words aligned to the SS frame,
// presents them through a one-deep valid/ready buffer and flags overruns and aborted frames.
module spi_word_assembler #(
  parameter int NUM_BYTES = 4,
  parameter bit MSB_FIRST = 1'b1,
  localparam int W  = 8 * NUM_BYTES,
  localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ss,
  input  logic          byte_valid,
  input  logic [7:0]    byte_in,
  input  logic          apply,
  input  logic          word_ready,
  input  logic          clear_err,
  output logic [W-1:0]  word_out,
  output logic          word_valid,
  output logic [CW-1:0] byte_count,
  output logic          overrun,
  output logic          frame_error
);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BYTES - 1);
  localparam int            BYTE_SH  = 8;

  // Shift arithmetic instead of part-selects keeps NUM_BYTES=1 legal.
  function automatic logic [W-1:0] shift_in(input logic [W-1:0] cur, input logic [7:0] b);
    logic [W-1:0] nxt;
    if (MSB_FIRST) begin
      nxt = (cur << BYTE_SH) | W'(b);
    end else begin
      nxt = (cur >> BYTE_SH) | (W'(b) << (W - BYTE_SH));
    end
    return nxt;
  endfunction

  state_t       state_r;
  logic [W-1:0] shift_r;

  logic         capture_s;
  logic         abort_s;
  logic         last_s;
  logic         drain_s;
  logic         load_s;
  logic         drop_s;
  logic [W-1:0] shifted_s;

  // Capture, completion and buffer-decision terms for this cycle.
  always_comb begin
    capture_s = byte_valid & apply & ~ss;
    abort_s   = ss & (byte_count != {CW{1'b0}});
    last_s    = capture_s & (byte_count == LAST_IDX);
    shifted_s = shift_in(shift_r, byte_in);
    drain_s   = word_valid & word_ready;
    load_s    = last_s & (~word_valid | word_ready);
    drop_s    = last_s & word_valid & ~word_ready;
  end

  // Frame FSM, accumulator, output buffer and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      shift_r     <= {W{1'b0}};
      byte_count  <= {CW{1'b0}};
      word_out    <= {W{1'b0}};
      word_valid  <= 1'b0;
      overrun     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!ss) state_r <= COLLECT;
          else     state_r <= IDLE;
        end
        COLLECT: begin
          if (ss) state_r <= IDLE;
          else    state_r <= COLLECT;
        end
        default: state_r <= IDLE;
      endcase

      // A partial word at frame end is discarded; ss high also blocks capture.
      if (abort_s) begin
        shift_r    <= {W{1'b0}};
        byte_count <= {CW{1'b0}};
      end else if (capture_s) begin
        shift_r    <= shifted_s;
        byte_count <= last_s ? {CW{1'b0}} : byte_count + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        shift_r    <= shift_r;
        byte_count <= byte_count;
      end

      if (load_s) begin
        word_out   <= shifted_s;
        word_valid <= 1'b1;
      end else if (drain_s) begin
        word_out   <= word_out;
        word_valid <= 1'b0;
      end else begin
        word_out   <= word_out;
        word_valid <= word_valid;
      end

      // A new error in the same cycle as clear_err keeps the flag set.
      overrun     <= drop_s  | (overrun & ~clear_err);
      frame_error <= abort_s | (frame_error & ~clear_err);
    end
  end

endmodule

// File: tb/tb_spi_word_assembler.sv
// Bench for spi_word_assembler: MSB-first and LSB-first instances share stimulus and
// are compared every cycle against a queue-based frame/word model.
module tb_spi_word_assembler;

  localparam int N = 4;
  localparam int W = 8 * N;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ss = 1'b1;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       apply = 1'b1;
  logic       word_ready = 1'b1;
  logic       clear_err = 1'b0;

  logic [W-1:0] wo_m, wo_l;
  logic         wv_m, wv_l, ov_m, ov_l, fe_m, fe_l;
  logic [1:0]   bc_m, bc_l;

  int checks = 0;
  int errors = 0;

  // model state
  logic [7:0]   q[$];
  logic [W-1:0] mw_m, mw_l;
  bit           mv, movr, mferr;

  always #5 clk = ~clk;

  spi_word_assembler #(.NUM_BYTES(N), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .ss(ss), .byte_valid(byte_valid), .byte_in(byte_in),
    .apply(apply), .word_ready(word_ready), .clear_err(clear_err),
    .word_out(wo_m), .word_valid(wv_m), .byte_count(bc_m), .overrun(ov_m), .frame_error(fe_m));

  spi_word_assembler #(.NUM_BYTES(N), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .ss(ss), .byte_valid(byte_valid), .byte_in(byte_in),
    .apply(apply), .word_ready(word_ready), .clear_err(clear_err),
    .word_out(wo_l), .word_valid(wv_l), .byte_count(bc_l), .overrun(ov_l), .frame_error(fe_l));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mw_m = '0; mw_l = '0; mv = 0; movr = 0; mferr = 0;
  endtask

  // First byte is most significant (msb=1) or least significant (msb=0).
  function automatic logic [W-1:0] pack(input bit msb);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < q.size(); i++) begin
      if (msb) w = w * 256 + W'(q[i]);
      else     w = w + (W'(q[i]) << (8 * i));
    end
    return w;
  endfunction

  task automatic model_edge();
    bit load, drop, abort;
    load = 0; drop = 0; abort = 0;
    if (ss && q.size() != 0) begin
      abort = 1;
      q.delete();
    end else if (byte_valid && apply && !ss) begin
      q.push_back(byte_in);
      if (q.size() == N) begin
        if (!mv || word_ready) begin
          load = 1;
          mw_m = pack(1'b1);
          mw_l = pack(1'b0);
        end else begin
          drop = 1;
        end
        q.delete();
      end
    end
    if (load) mv = 1;
    else if (mv && word_ready) mv = 0;
    movr  = drop  ? 1'b1 : (clear_err ? 1'b0 : movr);
    mferr = abort ? 1'b1 : (clear_err ? 1'b0 : mferr);
  endtask

  task automatic compare();
    check("word_out_m",  wo_m, mw_m);
    check("word_out_l",  wo_l, mw_l);
    check("valid_m",     wv_m, mv);
    check("valid_l",     wv_l, mv);
    check("count_m",     bc_m, q.size());
    check("count_l",     bc_l, q.size());
    check("overrun_m",   ov_m, movr);
    check("overrun_l",   ov_l, movr);
    check("frame_err_m", fe_m, mferr);
    check("frame_err_l", fe_l, mferr);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ap);
    byte_valid = 1'b1; byte_in = b; apply = ap;
    step();
    byte_valid = 1'b0; apply = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
  endtask

  initial begin
    logic [7:0] seq1[4];
    logic [1:0] cnt_exp[4];
    logic       ap_pat[6];
    seq1 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    cnt_exp = '{2'd1, 2'd2, 2'd3, 2'd0};
    ap_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    model_reset();
    @(negedge clk);
    compare();
    rst = 1'b1;
    step();

    // basic word, both byte orders
    ss = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      send_byte(seq1[i], 1'b1);
      check("count_seq", bc_m, cnt_exp[i]);
    end
    check("pin_msb_word", wo_m, 32'hDEADBEEF);
    check("pin_lsb_word", wo_l, 32'hEFBEADDE);
    check("pin_model_msb", mw_m, 32'hDEADBEEF);
    check("pin_valid_hi", wv_m, 1'b1);
    step();
    check("pin_valid_one_cycle", wv_m, 1'b0);

    // backpressure and overrun
    word_ready = 1'b0;
    send_word(32'h11223344);
    send_word(32'h55667788);
    check("pin_held_word", wo_m, 32'h11223344);
    check("pin_overrun", ov_m, 1'b1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("pin_overrun_clr", ov_m, 1'b0);
    send_byte(8'h99, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    word_ready = 1'b1;
    send_byte(8'hCC, 1'b1);
    check("pin_third_word", wo_m, 32'h99AABBCC);
    check("pin_no_retrigger", ov_m, 1'b0);
    step();

    // frame abort
    send_byte(8'h5A, 1'b1);
    send_byte(8'hA5, 1'b1);
    ss = 1'b1;
    step();
    check("pin_frame_err", fe_m, 1'b1);
    check("pin_abort_count", bc_m, 2'd0);
    check("pin_abort_novalid", wv_m, 1'b0);
    ss = 1'b0;
    step();
    send_word(32'h01020304);
    check("pin_after_abort", wo_m, 32'h01020304);
    step();
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("pin_fe_clr", fe_m, 1'b0);

    // apply gating
    for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i), ap_pat[i]);
    check("pin_gated_word", wo_m, 32'h10121315);
    ss = 1'b1;
    step();
    send_byte(8'h77, 1'b1);
    check("pin_ss_high_ignored", bc_m, 2'd0);
    check("pin_ss_high_no_fe", fe_m, 1'b0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      ss         = ($urandom_range(0, 19) == 0) ? ~ss : ss;
      byte_valid = ($urandom_range(0, 2) != 0);
      byte_in    = 8'($urandom);
      apply      = ($urandom_range(0, 7) != 0);
      word_ready = ($urandom_range(0, 2) != 0);
      clear_err  = ($urandom_range(0, 15) == 0);
      step();
    end
    byte_valid = 1'b0; apply = 1'b1; clear_err = 1'b0; word_ready = 1'b1;

    // asynchronous reset mid-word
    ss = 1'b0;
    step();
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("rst_word_m", wo_m, 32'h0);
    check("rst_valid_m", wv_m, 1'b0);
    check("rst_count_m", bc_m, 2'd0);
    check("rst_ovr_m", ov_m, 1'b0);
    check("rst_fe_m", fe_m, 1'b0);
    check("rst_word_l", wo_l, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step();
    send_word(32'hA1A2A3A4);
    check("pin_post_reset", wo_m, 32'hA1A2A3A4);
    check("pin_post_reset_l", wo_l, 32'hA4A3A2A1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
